// File: rtl/seq_extend_alu.sv
// Multi-cycle extended Hack ALU: plain ops, shifts, variable shifts, iterative multiply.
// Optional multiplier is enabled by defining SEQ_EXTEND_ALU_MUL_EN.
module seq_extend_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [8:0]       instruction,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [1:0]       run_sub;

  logic [1:0]       mode;
  logic [1:0]       sub;
  logic [SW-1:0]    k;
  logic             var_op;
  logic             mul_op;
  logic             iter;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] step_res;
  logic             unused_bit;

  assign mode       = instruction[8:7];
  assign sub        = instruction[5:4];
  assign k          = y[SW-1:0];
  assign unused_bit = instruction[6];
  assign var_op     = (mode == 2'b10);

`ifdef SEQ_EXTEND_ALU_MUL_EN
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             run_mul;
  logic [WIDTH-1:0] prod_nxt;
  assign mul_op = (mode == 2'b00);
`else
  assign mul_op = 1'b0;
`endif

  assign iter = mul_op | (var_op & (k != '0));

  function automatic logic [WIDTH-1:0] hack(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [5:0]       c
  );
    logic [WIDTH-1:0] xa;
    logic [WIDTH-1:0] yb;
    logic [WIDTH-1:0] r;
    xa = c[5] ? '0 : a;
    xa = c[4] ? ~xa : xa;
    yb = c[3] ? '0 : b;
    yb = c[2] ? ~yb : yb;
    r  = c[1] ? (xa + yb) : (xa & yb);
    r  = c[0] ? ~r : r;
    return r;
  endfunction

  // Covers modes 11/01, mode 10 with k=0, and mode 00 when no multiplier.
  always_comb begin
    single_res = hack(x, y, instruction[5:0]);
    unique case (1'b1)
      var_op: single_res = x;
      (mode == 2'b01): begin
        unique case (sub)
          2'b00: single_res = {y[WIDTH-1], y[WIDTH-1:1]};
          2'b01: single_res = {x[WIDTH-1], x[WIDTH-1:1]};
          2'b10: single_res = {y[WIDTH-2:0], 1'b0};
          default: single_res = {x[WIDTH-2:0], 1'b0};
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    shift_nxt = acc;
    unique case (run_sub)
      2'b00: shift_nxt = {acc[WIDTH-1], acc[WIDTH-1:1]};
      2'b01: shift_nxt = {1'b0, acc[WIDTH-1:1]};
      2'b10: shift_nxt = {acc[WIDTH-2:0], 1'b0};
      default: shift_nxt = {acc[WIDTH-2:0], acc[WIDTH-1]};
    endcase
  end

`ifdef SEQ_EXTEND_ALU_MUL_EN
  assign prod_nxt = acc + (mplier[0] ? mcand : '0);
  assign step_res = run_mul ? prod_nxt : shift_nxt;
`else
  assign step_res = shift_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      out     <= '0;
      cnt     <= '0;
      acc     <= '0;
      run_sub <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (iter) begin
              state   <= S_RUN;
              run_sub <= sub;
              if (mul_op) begin
                cnt <= CW'(WIDTH);
                acc <= '0;
              end else begin
                cnt <= {1'b0, k};
                acc <= x;
              end
            end else begin
              out   <= single_res;
              state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          cnt <= cnt - 1'b1;
          acc <= step_res;
          if (cnt == CW'(1)) begin
            out   <= step_res;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SEQ_EXTEND_ALU_MUL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      run_mul <= 1'b0;
    end else if (state == S_IDLE && in_valid) begin
      mcand   <= x;
      mplier  <= y;
      run_mul <= mul_op;
    end else if (state == S_RUN) begin
      mcand  <= {mcand[WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
    end
  end
`endif

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign zr        = (out == '0);
  assign ng        = out[WIDTH-1];

endmodule

// File: tb/tb_seq_extend_alu.sv
// Directed vector bench for seq_extend_alu (WIDTH=16).
// Expectations follow SEQ_EXTEND_ALU_MUL_EN when it is defined.
module tb_seq_extend_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic [8:0]  instruction = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out;
  logic        zr;
  logic        ng;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  seq_extend_alu #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .instruction(instruction), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .zr(zr), .ng(ng),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] vx;
    logic [15:0] vy;
    logic [8:0]  vi;
    logic [15:0] eo;
    int          el;
  } vec_t;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [15:0] vx, input logic [15:0] vy,
                       input logic [8:0] vi, output int lat);
    @(negedge clk);
    x = vx; y = vy; instruction = vi; in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = ~vx; y = ~vy; instruction = ~vi;
    check("in_ready_drop", in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) check("timeout", 0, 1);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ready_back", in_ready, 1);
    check("valid_drop", out_valid, 0);
  endtask

  vec_t vt[12];
  int   lat;

  initial begin
    vt[0]  = '{"add",      16'd5,    16'd3,  9'b110000010, 16'h0008, 1};
    vt[1]  = '{"sub",      16'd3,    16'd5,  9'b110010011, 16'hFFFE, 1};
    vt[2]  = '{"zero",     16'h1234, 16'h55, 9'b110101010, 16'h0000, 1};
    vt[3]  = '{"sx_sra1",  16'hFFFA, 16'h0,  9'b010010000, 16'hFFFD, 1};
    vt[4]  = '{"sy_shl1",  16'h0,    16'h4001, 9'b010100000, 16'h8002, 1};
    vt[5]  = '{"vshl15",   16'h0001, 16'd15, 9'b100100000, 16'h8000, 16};
    vt[6]  = '{"vk0",      16'h1234, 16'd0,  9'b100100000, 16'h1234, 1};
    vt[7]  = '{"vrol1",    16'h8001, 16'd1,  9'b100110000, 16'h0003, 2};
    vt[8]  = '{"vsra4",    16'h8000, 16'd4,  9'b100000000, 16'hF800, 5};
    vt[9]  = '{"vsrl4",    16'h8000, 16'd4,  9'b100010000, 16'h0800, 5};
`ifdef SEQ_EXTEND_ALU_MUL_EN
    vt[10] = '{"mul_neg",  16'hFFFD, 16'd7,  9'b000000000, 16'hFFEB, 17};
    vt[11] = '{"mul_wrap", 16'h0100, 16'h0100, 9'b000000000, 16'h0000, 17};
`else
    vt[10] = '{"mul_neg",  16'hFFFD, 16'd7,  9'b000000000, 16'h0005, 1};
    vt[11] = '{"mul_wrap", 16'h0100, 16'h0100, 9'b000000000, 16'h0100, 1};
`endif

    #12;
    check("rst_out", out, 0);
    check("rst_zr", zr, 1);
    check("rst_ng", ng, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      issue(vt[i].vx, vt[i].vy, vt[i].vi, lat);
      check({vt[i].name, "_out"}, out, vt[i].eo);
      check({vt[i].name, "_zr"}, zr, (vt[i].eo == 16'h0));
      check({vt[i].name, "_ng"}, ng, vt[i].eo[15]);
      check({vt[i].name, "_lat"}, lat, vt[i].el);
      consume();
    end

    // Result must hold and no new accept while DONE waits for out_ready.
    issue(16'd5, 16'd3, 9'b110000010, lat);
    @(negedge clk);
    in_valid = 1'b1;
    instruction = 9'b110000010;
    y = 16'd1;
    for (int c = 0; c < 5; c++) begin
      x = 16'(c * 7 + 100);
      @(posedge clk); #1;
      check("hold_out", out, 16'h0008);
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    consume();

    // Abort a long op with reset mid-RUN.
    @(negedge clk);
`ifdef SEQ_EXTEND_ALU_MUL_EN
    x = 16'hFFFD; y = 16'd7; instruction = 9'b000000000;
`else
    x = 16'h0001; y = 16'd15; instruction = 9'b100100000;
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_ready", in_ready, 1);
    check("abort_out", out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'd5, 16'd3, 9'b110000010, lat);
    check("post_out", out, 16'h0008);
    check("post_lat", lat, 1);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
